// File: rtl/lin_pid_table.sv
// LIN protected-ID lookup table.
// A small register table of {valid, dir, nad, id} entries is searched
// sequentially, one entry per cycle, for a captured {dir, nad, id} key.
// The protected-ID parity is checked before the scan starts. A lookup
// with bad parity finishes at once and never touches the table.
module lin_pid_table #(
    parameter int DEPTH = 16,
    parameter int NAD_W = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic             cfg_valid,
    input  logic             cfg_dir,
    input  logic [NAD_W-1:0] cfg_nad,
    input  logic [5:0]       cfg_id,
    input  logic             cfg_clr,
    input  logic             lk_req,
    input  logic             lk_dir,
    input  logic [NAD_W-1:0] lk_nad,
    input  logic [7:0]       lk_pid,
    output logic             lk_busy,
    output logic             lk_done,
    output logic             lk_hit,
    output logic             lk_perr,
    output logic [IDX_W-1:0] lk_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Expected {P1, P0} for a 6-bit frame identifier.
    function automatic logic [1:0] pid_parity(input logic [5:0] id);
        logic p0;
        logic p1;
        p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
        p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
        return {p1, p0};
    endfunction

    // Table storage
    logic             tbl_valid_q [DEPTH];
    logic             tbl_dir_q   [DEPTH];
    logic [NAD_W-1:0] tbl_nad_q   [DEPTH];
    logic [5:0]       tbl_id_q    [DEPTH];

    // Lookup engine state
    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             key_dir_q, key_dir_d;
    logic [NAD_W-1:0] key_nad_q, key_nad_d;
    logic [5:0]       key_id_q, key_id_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic             perr_q, perr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             entry_match_s;
    logic             parity_ok_s;

    // Table write port: clear beats a same-cycle write; active in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_valid_q[i] <= 1'b0;
                tbl_dir_q[i]   <= 1'b0;
                tbl_nad_q[i]   <= '0;
                tbl_id_q[i]    <= 6'd0;
            end
        end else if (cfg_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_valid_q[i] <= 1'b0;
            end
        end else if (cfg_we && (int'(cfg_idx) < DEPTH)) begin
            tbl_valid_q[cfg_idx] <= cfg_valid;
            tbl_dir_q[cfg_idx]   <= cfg_dir;
            tbl_nad_q[cfg_idx]   <= cfg_nad;
            tbl_id_q[cfg_idx]    <= cfg_id;
        end
    end

    // Compare the entry under the scan pointer with the captured key and check request parity.
    always_comb begin
        entry_match_s = tbl_valid_q[cnt_q]
                        && (tbl_dir_q[cnt_q] == key_dir_q)
                        && (tbl_nad_q[cnt_q] == key_nad_q)
                        && (tbl_id_q[cnt_q]  == key_id_q);
        parity_ok_s   = (pid_parity(lk_pid[5:0]) == lk_pid[7:6]);
    end

    // Next-state logic of the lookup FSM; results change only on entry to DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_dir_d = key_dir_q;
        key_nad_d = key_nad_q;
        key_id_d  = key_id_q;
        hit_d     = hit_q;
        perr_d    = perr_q;
        idx_d     = idx_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lk_req) begin
                    key_dir_d = lk_dir;
                    key_nad_d = lk_nad;
                    key_id_d  = lk_pid[5:0];
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    if (parity_ok_s) begin
                        state_d = ST_SCAN;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hit_d   = 1'b0;
                        perr_d  = 1'b1;
                        idx_d   = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                busy_d = 1'b1;
                if (entry_match_s) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    hit_d   = 1'b1;
                    perr_d  = 1'b0;
                    idx_d   = cnt_q;
                end else if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    hit_d   = 1'b0;
                    perr_d  = 1'b0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Lookup FSM, key and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            key_dir_q <= 1'b0;
            key_nad_q <= '0;
            key_id_q  <= 6'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            perr_q    <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_dir_q <= key_dir_d;
            key_nad_q <= key_nad_d;
            key_id_q  <= key_id_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            perr_q    <= perr_d;
            idx_q     <= idx_d;
        end
    end

    assign lk_busy = busy_q;
    assign lk_done = done_q;
    assign lk_hit  = hit_q;
    assign lk_perr = perr_q;
    assign lk_idx  = idx_q;

endmodule

// File: tb/tb_lin_pid_table.sv
// Self-checking bench for lin_pid_table: directed cases plus randomized
// lookups checked against a simple array model of the table.
module tb_lin_pid_table;

    localparam int DEPTH = 16;
    localparam int NAD_W = 4;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we, cfg_valid, cfg_dir, cfg_clr;
    logic [IDX_W-1:0] cfg_idx;
    logic [NAD_W-1:0] cfg_nad;
    logic [5:0]       cfg_id;
    logic             lk_req, lk_dir;
    logic [NAD_W-1:0] lk_nad;
    logic [7:0]       lk_pid;
    logic             lk_busy, lk_done, lk_hit, lk_perr;
    logic [IDX_W-1:0] lk_idx;

    int checks = 0;
    int errors = 0;

    // Reference table
    bit         m_valid [DEPTH];
    bit         m_dir   [DEPTH];
    logic [3:0] m_nad   [DEPTH];
    logic [5:0] m_id    [DEPTH];

    always #5 clk = ~clk;

    lin_pid_table #(.DEPTH(DEPTH), .NAD_W(NAD_W)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
        .cfg_dir(cfg_dir), .cfg_nad(cfg_nad), .cfg_id(cfg_id), .cfg_clr(cfg_clr),
        .lk_req(lk_req), .lk_dir(lk_dir), .lk_nad(lk_nad), .lk_pid(lk_pid),
        .lk_busy(lk_busy), .lk_done(lk_done), .lk_hit(lk_hit),
        .lk_perr(lk_perr), .lk_idx(lk_idx)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Protected ID built from the parity rules with bit masks.
    function automatic logic [7:0] mk_pid(input logic [5:0] id);
        logic p0, p1;
        p0 = ^(id & 6'b010111);
        p1 = ~(^(id & 6'b111010));
        return {p1, p0, id};
    endfunction

    task automatic chk_all_zero(input string tag);
        check({tag, "_busy"}, lk_busy, 0);
        check({tag, "_done"}, lk_done, 0);
        check({tag, "_hit"},  lk_hit,  0);
        check({tag, "_perr"}, lk_perr, 0);
        check({tag, "_idx"},  lk_idx,  0);
    endtask

    // Called at a negedge; holds reset with noisy inputs, returns at a negedge.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        cfg_we = 1'b1; cfg_idx = 4'd1; cfg_valid = 1'b1; cfg_dir = 1'b0;
        cfg_nad = 4'd1; cfg_id = 6'h3C;
        lk_req = 1'b1; lk_dir = 1'b0; lk_nad = 4'd1; lk_pid = 8'h3C;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all_zero(tag);
        end
        rst = 1'b0; cfg_we = 1'b0; lk_req = 1'b0;
    endtask

    task automatic cfg_write(input bit clr, input bit we, input int idx, input bit v,
                             input bit dir, input logic [3:0] nad, input logic [5:0] id);
        @(negedge clk);
        cfg_clr = clr; cfg_we = we; cfg_idx = IDX_W'(idx);
        cfg_valid = v; cfg_dir = dir; cfg_nad = nad; cfg_id = id;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        end else if (we) begin
            m_valid[idx] = v; m_dir[idx] = dir; m_nad[idx] = nad; m_id[idx] = id;
        end
        @(negedge clk);
        cfg_clr = 1'b0; cfg_we = 1'b0;
    endtask

    // One lookup; optional write to the entry being compared (wr_en) during the scan.
    task automatic lookup(input string tag, input bit dir, input logic [3:0] nad,
                          input logic [7:0] pid, input bit wr_en, input int wr_idx,
                          input bit wr_v);
        int  exp_lat, exp_idx, cyc;
        bit  exp_hit, exp_perr, seen;
        exp_hit = 1'b0; exp_perr = 1'b0; exp_idx = 0;
        if (pid != mk_pid(pid[5:0])) begin
            exp_perr = 1'b1;
            exp_lat  = 1;
        end else begin
            exp_lat = DEPTH + 1;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (m_valid[k] && m_dir[k] == dir && m_nad[k] == nad && m_id[k] == pid[5:0]) begin
                    exp_hit = 1'b1; exp_idx = k; exp_lat = k + 2;
                end
            end
        end
        @(negedge clk);
        lk_req = 1'b1; lk_dir = dir; lk_nad = nad; lk_pid = pid;
        seen = 1'b0; cyc = 0;
        for (int i = 1; i <= 2 * DEPTH + 8 && !seen; i++) begin
            @(negedge clk);
            cfg_we = 1'b0;
            check({tag, "_busy"}, lk_busy, 1);
            if (lk_done) begin
                seen = 1'b1; cyc = i;
                lk_req = 1'b0;
            end else begin
                lk_req = 1'($urandom_range(0, 1));
                lk_dir = 1'($urandom); lk_nad = 4'($urandom); lk_pid = 8'($urandom);
            end
            if (wr_en && i == wr_idx + 1) begin
                cfg_we = 1'b1; cfg_idx = IDX_W'(wr_idx); cfg_valid = wr_v;
                cfg_dir = dir; cfg_nad = nad; cfg_id = pid[5:0];
                m_valid[wr_idx] = wr_v; m_dir[wr_idx] = dir;
                m_nad[wr_idx] = nad; m_id[wr_idx] = pid[5:0];
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_lat"},  cyc,     exp_lat);
            check({tag, "_hit"},  lk_hit,  exp_hit);
            check({tag, "_perr"}, lk_perr, exp_perr);
            check({tag, "_idx"},  lk_idx,  exp_idx);
        end
        @(negedge clk);
        cfg_we = 1'b0;
        lk_req = 1'b0;
        check({tag, "_done_pulse"}, lk_done, 0);
        check({tag, "_idle"},       lk_busy, 0);
        check({tag, "_hold_hit"},   lk_hit,  exp_hit);
        check({tag, "_hold_idx"},   lk_idx,  exp_idx);
    endtask

    logic [5:0] ids [3];

    initial begin
        ids[0] = 6'h23; ids[1] = 6'h3C; ids[2] = 6'h05;
        cfg_clr = 1'b0; cfg_we = 1'b0; lk_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        do_reset("reset");

        // Full miss on an empty table.
        lookup("miss_empty", 1'b0, 4'd1, 8'h3C, 1'b0, 0, 1'b0);

        // Hit at index 3.
        cfg_write(1'b0, 1'b1, 3, 1'b1, 1'b1, 4'h0, 6'h23);
        lookup("hit3", 1'b1, 4'd0, 8'hA3, 1'b0, 0, 1'b0);

        // Parity error; result must replace the previous hit.
        lookup("perr", 1'b1, 4'd0, 8'h23, 1'b0, 0, 1'b0);

        // Duplicates and direction.
        cfg_write(1'b0, 1'b1, 2, 1'b1, 1'b0, 4'd5, 6'h3C);
        cfg_write(1'b0, 1'b1, 9, 1'b1, 1'b0, 4'd5, 6'h3C);
        lookup("dup", 1'b0, 4'd5, 8'h3C, 1'b0, 0, 1'b0);
        lookup("dirflip", 1'b1, 4'd5, 8'h3C, 1'b0, 0, 1'b0);

        // Invalidate entry 2 while it is under compare: the old value still hits.
        lookup("wr_collide", 1'b0, 4'd5, 8'h3C, 1'b1, 2, 1'b0);
        lookup("after_collide", 1'b0, 4'd5, 8'h3C, 1'b0, 0, 1'b0);

        // Clear together with write: all invalid, write dropped.
        cfg_write(1'b1, 1'b1, 4, 1'b1, 1'b1, 4'd2, 6'h05);
        lookup("clr_we_a", 1'b1, 4'd2, mk_pid(6'h05), 1'b0, 0, 1'b0);
        lookup("clr_we_b", 1'b0, 4'd5, 8'h3C, 1'b0, 0, 1'b0);

        // Reset in the middle of a scan.
        cfg_write(1'b0, 1'b1, 7, 1'b1, 1'b1, 4'd3, 6'h05);
        @(negedge clk);
        lk_req = 1'b1; lk_dir = 1'b0; lk_nad = 4'd9; lk_pid = 8'h3C;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            lk_req = 1'b0;
            check("midrst_nodone", lk_done, 0);
        end
        do_reset("midrst");
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(negedge clk);
            check("midrst_quiet", lk_done, 0);
        end
        lookup("midrst_after", 1'b1, 4'd3, mk_pid(6'h05), 1'b0, 0, 1'b0);

        // Randomized table traffic and lookups.
        for (int n = 0; n < 40; n++) begin
            int        idx;
            bit        d;
            logic [3:0] nd;
            logic [5:0] id;
            logic [7:0] pid;
            if ($urandom_range(0, 19) == 0) begin
                cfg_write(1'b1, 1'($urandom), 0, 1'b1, 1'b0, 4'd0, 6'd0);
            end
            for (int w = 0; w < 2; w++) begin
                cfg_write(1'b0, 1'b1, $urandom_range(0, DEPTH - 1), ($urandom_range(0, 3) != 0),
                          1'($urandom), 4'($urandom_range(0, 1)), ids[$urandom_range(0, 2)]);
            end
            d   = 1'($urandom);
            nd  = 4'($urandom_range(0, 1));
            id  = ids[$urandom_range(0, 2)];
            pid = mk_pid(id);
            if ($urandom_range(0, 6) == 0) pid[7:6] = pid[7:6] ^ 2'($urandom_range(1, 3));
            idx = $urandom_range(0, DEPTH - 1);
            lookup("rand", d, nd, pid, ($urandom_range(0, 3) == 0), idx, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lin_pid_table.md
LIN_PID_TABLE -- requirements
Module: lin_pid_table

Interface
REQ-001 Parameter DEPTH, default 16, number of table entries (2..64).
REQ-002 Parameter NAD_W, default 4, node address width.
REQ-003 Ports clk in 1: single clock. All logic is on the rising edge.
REQ-004 Ports rst in 1: reset is synchronous and active-high.
REQ-005 Ports cfg_we in 1: write one table entry this cycle.
REQ-006 Ports cfg_idx in clog2(DEPTH): the entry to write.
REQ-007 Ports cfg_valid in 1, cfg_dir in 1 (1=publisher, 0=subscriber), cfg_nad in NAD_W, cfg_id in 6: the entry contents.
REQ-008 Ports cfg_clr in 1: invalidate all entries.
REQ-009 Ports lk_req in 1, lk_dir in 1, lk_nad in NAD_W, lk_pid in 8: the lookup request, where lk_pid is the full protected ID {P1,P0,ID[5:0]}.
REQ-010 Ports lk_busy out 1, lk_done out 1, lk_hit out 1, lk_perr out 1, lk_idx out clog2(DEPTH): the lookup status and result.

Function
REQ-011 Table entry contents: {valid, dir, nad, id[5:0]}. Entries are held in registers.
REQ-012 Write, cfg_clr: clears every valid bit at the clock edge.
REQ-013 Write, cfg_we without cfg_clr: writes entry cfg_idx at the clock edge.
REQ-014 Write priority: when cfg_clr and cfg_we are asserted in the same cycle, cfg_clr wins and the write is dropped.
REQ-015 Write availability: writes are accepted in every state, including during a scan.
REQ-016 Parity: P0 = ID0^ID1^ID2^ID4 and P1 = ~(ID1^ID3^ID4^ID5), computed on lk_pid[5:0].
REQ-017 Parity error: a mismatch with lk_pid[7:6] is a parity error.
REQ-018 FSM states: IDLE, SCAN, DONE. The FSM resets to IDLE.
REQ-019 IDLE: lk_req=1 captures lk_dir, lk_nad and lk_pid[5:0] and clears the scan counter to 0.
REQ-020 IDLE, good parity: the next state is SCAN.
REQ-021 IDLE, bad parity: the next state is DONE with lk_perr=1, lk_hit=0 and lk_idx=0.
REQ-022 SCAN: each cycle compares entry[cnt] against the captured key. A match needs valid=1, dir equal, nad equal and id equal.
REQ-023 SCAN, match: lk_hit=1, lk_idx=cnt, lk_perr=0, and the next state is DONE.
REQ-024 SCAN, no match with cnt=DEPTH-1: lk_hit=0, lk_idx=0, lk_perr=0, and the next state is DONE.
REQ-025 SCAN, no match with cnt<DEPTH-1: cnt increments.
REQ-026 Match order: the lowest matching index wins.
REQ-027 DONE: lk_done=1 for exactly one cycle, then the FSM returns to IDLE. No new request is accepted in DONE.
REQ-028 Busy and request handling: lk_busy=1 in SCAN and DONE. lk_req is ignored while lk_busy=1 and is not queued.
REQ-029 Latency, request sampled at edge 0: a match at index k gives lk_done in cycle k+2.
REQ-030 Latency, full miss: lk_done in cycle DEPTH+1.
REQ-031 Latency, parity error: lk_done in cycle 1.
REQ-032 Result hold: lk_hit, lk_idx and lk_perr are registered and hold their value until the next lookup reaches DONE.
REQ-033 Write/scan collision: a compare in a cycle sees the table contents stored before that cycle's edge. A write to entry[cnt] in the same cycle affects only later lookups.
REQ-034 Key capture: changes on the lk_* inputs after capture have no effect on the lookup in progress.

Reset
REQ-035 Reset values: while rst=1 at an edge, all valid bits=0, state=IDLE, cnt=0, and lk_busy, lk_done, lk_hit, lk_perr and lk_idx=0.
REQ-036 Reset mid-scan: the lookup is aborted and no lk_done is produced. cfg_we and lk_req are ignored while rst=1.

Verification
REQ-037 Hit: write idx 3 = {1,1,4'h0,6'h23}; request dir=1, nad=0, pid=8'hA3 → lk_done in cycle 5, lk_hit=1, lk_idx=3, lk_perr=0.
REQ-038 Parity error: request pid=8'h23 (bad parity for ID 0x23) → lk_done in cycle 1, lk_perr=1, lk_hit=0, table not scanned.
REQ-039 Full miss: empty table after reset; request dir=0, nad=1, pid=8'h3C → lk_done in cycle 17 (DEPTH=16), lk_hit=0, lk_idx=0.
REQ-040 Duplicates and direction:
- Identical entries at idx 2 and 9 → lk_idx=2.
- Same key with the dir bit flipped → miss.
REQ-041 Collisions:
- During SCAN, assert lk_req → ignored and lk_busy stays 1.
- Write to the entry under compare → the old value is used.
- cfg_clr together with cfg_we → all entries invalid.
REQ-042 Reset mid-scan: rst=1 in cycle 3 of a scan → no lk_done, all outputs 0, next lookup of any key misses.
